// File: rtl/fifo_read_ctrl.sv
// Reader-side FIFO controller: pops into a 2-entry skid buffer, delivers over valid/ready, counts words.
// Pop-to-m_valid latency 2 cycles; downstream stalls stop new pops once buffer plus in-flight reaches 2.

package bus_definitions;
    parameter int ws = 4;

    typedef enum logic [3:0] {
        idle          = 4'b0001,
        insert        = 4'b0010,
        remove        = 4'b0100,
        insert_remove = 4'b1000
    } fifo_fsm_states_t;
endpackage

module fifo_read_ctrl
    import bus_definitions::*;
#(
    parameter int WS    = bus_definitions::ws,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WS-1:0]    fifo_rd_data,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WS-1:0]    m_data,
    output logic [CNT_W-1:0] words_out,
    output logic             busy
);

    logic [1:0]       r_occ;
    logic             r_inflight;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [WS-1:0]    r_buf [2];
    logic [CNT_W-1:0] r_words_out;
    fifo_fsm_states_t r_state;

    fifo_fsm_states_t w_state_nxt;
    logic [1:0]       w_occ_nxt;
    logic             w_capture;
    logic             w_drain;
    logic [2:0]       w_level;

    assign w_capture = r_inflight;
    assign w_drain   = m_valid && m_ready;
    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf[r_rd_ptr];
    assign busy      = m_valid || r_inflight;
    assign words_out = r_words_out;

    // Counting the slot freed by this cycle's drain keeps full throughput without ever overrunning the buffer.
    assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_drain};
    assign fifo_pop = rst_n && enable && !fifo_empty && (w_level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= idle;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_pop;
        end
    end

    always_comb begin
        w_state_nxt = idle;
        w_occ_nxt   = r_occ;
        case ({w_capture, w_drain})
            2'b10: begin
                w_state_nxt = insert;
                w_occ_nxt   = r_occ + 2'd1;
            end
            2'b01: begin
                w_state_nxt = remove;
                w_occ_nxt   = r_occ - 2'd1;
            end
            2'b11: begin
                w_state_nxt = insert_remove;
            end
            default: begin
                w_state_nxt = idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_words_out <= '0;
        end else begin
            if (w_capture) begin
                r_buf[r_wr_ptr] <= fifo_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_drain) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_words_out <= r_words_out + 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2);
    a_state_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(r_state));
    a_insert_fills: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == insert || r_state == insert_remove) |-> (r_occ != 2'd0));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: behavioural FIFO with 1-cycle read latency plus in-order delivery scoreboard.
module tb_fifo_read_ctrl;
    localparam int WS    = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             fifo_empty;
    logic [WS-1:0]    fifo_rd_data;
    logic             fifo_pop;
    logic             m_valid;
    logic             m_ready;
    logic [WS-1:0]    m_data;
    logic [CNT_W-1:0] words_out;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int wr_cnt;
    int rd_cnt;
    int deliv;
    int pops;
    logic pend;
    logic [WS-1:0] mem [256];

    typedef struct {
        logic             en;
        logic             rdy;
        logic             exp_pop;
        logic             exp_vld;
        logic [WS-1:0]    exp_dat;
        logic             exp_busy;
        logic [CNT_W-1:0] exp_wo;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    fifo_read_ctrl #(.WS(WS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_pop     (fifo_pop),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .words_out    (words_out),
        .busy         (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [WS-1:0] w);
        mem[wr_cnt[7:0]] = w;
        wr_cnt++;
        fifo_empty = (rd_cnt == wr_cnt);
    endtask

    // Negedge: record this cycle's pop and check any word handed downstream.
    task automatic sample();
        @(negedge clk);
        pend = fifo_pop;
        if (fifo_pop) begin
            pops++;
            chk("no_pop_when_empty", int'(fifo_empty), 0);
        end
        chk("occ_plus_inflight_le2", int'(({1'b0, dut.r_occ} + {2'b00, dut.r_inflight}) <= 3'd2), 1);
        if (m_valid && m_ready) begin
            chk("deliver_not_extra", int'(deliv < wr_cnt), 1);
            chk("deliver_data", int'(m_data), int'(mem[deliv[7:0]]));
            deliv++;
        end
    endtask

    // Just after posedge: FIFO returns the popped word; otherwise a value that differs from the next word.
    task automatic advance();
        @(posedge clk);
        #1;
        if (pend) begin
            fifo_rd_data = mem[rd_cnt[7:0]];
            rd_cnt++;
        end else begin
            fifo_rd_data = ~mem[rd_cnt[7:0]];
        end
        fifo_empty = (rd_cnt == wr_cnt);
    endtask

    task automatic bench_clear();
        enable       = 1'b0;
        m_ready      = 1'b0;
        wr_cnt       = 0;
        rd_cnt       = 0;
        deliv        = 0;
        pops         = 0;
        pend         = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bench_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && deliv < n; i++) begin
            sample();
            advance();
        end
        chk("delivered_count", deliv, n);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 4'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 4'd2};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd3};

        // Reset state
        do_reset();
        chk("rst_pop", int'(fifo_pop), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_words_out", int'(words_out), 0);
        chk("rst_m_data", int'(m_data), 0);

        // Three preloaded words at full rate, cycle by cycle
        push(4'h1); push(4'h2); push(4'h3);
        for (int k = 0; k < 6; k++) begin
            enable  = vecs[k].en;
            m_ready = vecs[k].rdy;
            sample();
            chk($sformatf("v%0d_pop", k), int'(fifo_pop), int'(vecs[k].exp_pop));
            chk($sformatf("v%0d_m_valid", k), int'(m_valid), int'(vecs[k].exp_vld));
            if (vecs[k].exp_vld) chk($sformatf("v%0d_m_data", k), int'(m_data), int'(vecs[k].exp_dat));
            chk($sformatf("v%0d_busy", k), int'(busy), int'(vecs[k].exp_busy));
            chk($sformatf("v%0d_words_out", k), int'(words_out), int'(vecs[k].exp_wo));
            advance();
        end
        chk("t1_pops", pops, 3);

        // Backpressure: only two pops, head word held stable, then drain all five
        do_reset();
        push(4'h9); push(4'h8); push(4'h7); push(4'h6); push(4'h5);
        enable = 1'b1;
        repeat (6) begin sample(); advance(); end
        chk("t2_pops_stalled", pops, 2);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t2_pop_low", int'(fifo_pop), 0);
            chk("t2_occ", int'(dut.r_occ), 2);
            chk("t2_m_valid", int'(m_valid), 1);
            chk("t2_m_data_stable", int'(m_data), 9);
            advance();
        end
        m_ready = 1'b1;
        run_until(5, 50);
        sample();
        chk("t2_words_out", int'(words_out), 5);
        chk("t2_busy_idle", int'(busy), 0);
        advance();

        // Toggling m_ready with 100 words: no loss, no duplication
        do_reset();
        for (int i = 0; i < 100; i++) push(WS'(i * 7 + 3));
        enable = 1'b1;
        for (int i = 0; i < 800 && deliv < 100; i++) begin
            sample();
            advance();
            m_ready = ~m_ready;
        end
        chk("t3_delivered", deliv, 100);
        sample();
        chk("t3_pops", pops, 100);
        chk("t3_words_out_mod16", int'(words_out), 100 % 16);
        chk("t3_busy_idle", int'(busy), 0);
        advance();

        // Enable dropped right after a pop: that one word still arrives
        do_reset();
        push(4'h5); push(4'h6); push(4'h7);
        m_ready = 1'b1;
        enable  = 1'b1;
        sample();
        chk("t4_first_pop", int'(fifo_pop), 1);
        advance();
        enable = 1'b0;
        sample();
        chk("t4_pop_after_disable", int'(fifo_pop), 0);
        chk("t4_busy_inflight", int'(busy), 1);
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t4_pop_held_low", int'(fifo_pop), 0);
            advance();
        end
        chk("t4_delivered", deliv, 1);
        chk("t4_words_out", int'(words_out), 1);
        chk("t4_m_valid_low", int'(m_valid), 0);

        // Asynchronous reset with a buffered word and one in flight
        do_reset();
        for (int i = 0; i < 8; i++) push(WS'(i + 10));
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (6) begin sample(); advance(); end
        m_ready = 1'b0;
        chk("t5_pre_occ", int'(dut.r_occ), 1);
        chk("t5_pre_inflight", int'(dut.r_inflight), 1);
        chk("t5_pre_words_out", int'(words_out), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_m_valid", int'(m_valid), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_words_out", int'(words_out), 0);
        chk("t5_async_pop", int'(fifo_pop), 0);
        chk("t5_async_m_data", int'(m_data), 0);
        bench_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t5_no_stale_valid", int'(m_valid), 0);
            chk("t5_no_stale_busy", int'(busy), 0);
            advance();
        end

        // 17 words through a 4-bit counter wraps it to 1
        do_reset();
        for (int i = 0; i < 17; i++) push(WS'(15 - i));
        enable  = 1'b1;
        m_ready = 1'b1;
        run_until(17, 100);
        sample();
        chk("t6_words_out_wrap", int'(words_out), 1);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
